// File: rtl/fetch_queue.sv
// Instruction fetch queue: predecodes each fetched word to steer fq_pc and buffers DEPTH entries for the decoder.
// Head entry is visible combinationally; fetch requests stop while full, and rdy=0 freezes all state.
module fetch_queue #(
  parameter int unsigned            XLEN     = 32,
  parameter int unsigned            DEPTH    = 4,
  parameter logic [XLEN-1:0]        RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          flush,
  input  logic [XLEN-1:0]               rob_correct_pc,
  input  logic                          bp_pred,
  input  logic                          icache_ready,
  input  logic [XLEN-1:0]               icache_inst,
  input  logic                          mem_inst_ready,
  input  logic [XLEN-1:0]               mem_inst,
  output logic                          fq_icache_enable,
  output logic [XLEN-1:0]               fq_pc,
  input  logic                          dec_accept,
  output logic                          fq_valid,
  output logic [XLEN-1:0]               fq_inst,
  output logic [XLEN-1:0]               fq_inst_addr,
  output logic                          fq_jump_pred,
  output logic [$clog2(DEPTH):0]        fq_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] r_inst [DEPTH];
  logic [XLEN-1:0] r_addr [DEPTH];
  logic            r_pred [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_pc;
  logic            r_started;

  logic            w_enable;
  logic            w_enq;
  logic            w_deq;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_cj;
  logic [XLEN-1:0] w_imm_cb;
  logic [XLEN-1:0] w_next_pc;
  logic            w_pred;

  // Enable already excludes the full case, so a dequeue never makes room for a same-cycle enqueue.
  assign w_enable = r_started & (r_count != CW'(DEPTH));
  assign w_enq    = w_enable & (icache_ready | mem_inst_ready);
  assign w_deq    = (r_count != '0) & dec_accept;
  assign w_word   = icache_ready ? icache_inst : mem_inst;

  assign w_imm_j  = {{(XLEN-21){w_word[31]}}, w_word[31], w_word[19:12], w_word[20], w_word[30:21], 1'b0};
  assign w_imm_b  = {{(XLEN-13){w_word[31]}}, w_word[31], w_word[7], w_word[30:25], w_word[11:8], 1'b0};
  assign w_imm_cj = {{(XLEN-12){w_word[12]}}, w_word[12], w_word[8], w_word[10:9], w_word[6],
                     w_word[7], w_word[2], w_word[11], w_word[5:3], 1'b0};
  assign w_imm_cb = {{(XLEN-9){w_word[12]}}, w_word[12], w_word[6:5], w_word[2], w_word[11:10],
                     w_word[4:3], 1'b0};

  always_comb begin
    w_next_pc = r_pc + XLEN'(2);
    w_pred    = 1'b0;
    if (w_word[1:0] == 2'b11) begin
      w_next_pc = r_pc + XLEN'(4);
      if (w_word[6:0] == 7'b1101111) begin
        w_next_pc = r_pc + w_imm_j;
        w_pred    = 1'b1;
      end else if (w_word[6:0] == 7'b1100011) begin
        w_pred = bp_pred;
        if (bp_pred) w_next_pc = r_pc + w_imm_b;
      end
    end else if (w_word[1:0] == 2'b01 && w_word[14:13] == 2'b01) begin
      w_next_pc = r_pc + w_imm_cj;
      w_pred    = 1'b1;
    end else if (w_word[1:0] == 2'b01 && w_word[15:14] == 2'b11) begin
      w_pred = bp_pred;
      if (bp_pred) w_next_pc = r_pc + w_imm_cb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_pc      <= RESET_PC;
      r_started <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_inst[i] <= '0;
        r_addr[i] <= '0;
        r_pred[i] <= 1'b0;
      end
    end else if (rdy) begin
      r_started <= 1'b1;
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_pc    <= rob_correct_pc;
      end else begin
        if (w_enq) begin
          r_inst[r_tail] <= w_word;
          r_addr[r_tail] <= r_pc;
          r_pred[r_tail] <= w_pred;
          r_tail         <= r_tail + AW'(1);
          r_pc           <= w_next_pc;
        end
        if (w_deq) r_head <= r_head + AW'(1);
        r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      end
    end
  end

  assign fq_icache_enable = w_enable;
  assign fq_pc            = r_pc;
  assign fq_valid         = (r_count != '0);
  assign fq_inst          = r_inst[r_head];
  assign fq_inst_addr     = r_addr[r_head];
  assign fq_jump_pred     = r_pred[r_head];
  assign fq_count         = r_count;

endmodule
